// File: rtl/vc_arbiter_sched.sv
// vc_arbiter_sched: weighted two-VC scheduler feeding two destination FIFOs.
// VC0 gets up to VC0_WEIGHT back-to-back grants before VC1 gets one.
// Popped words land in the destination FIFO two cycles later, steered by one bit of the word.
module vc_arbiter_sched #(
   parameter int BW         = 6,
   parameter int DEST_BIT   = 4,
   parameter int VC0_WEIGHT = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          active_in,
   input  logic          vc0_empty,
   input  logic          vc1_empty,
   input  logic [BW-1:0] vc0_data,
   input  logic [BW-1:0] vc1_data,
   input  logic          d0_almost_full,
   input  logic          d1_almost_full,
   output logic          vc0_pop,
   output logic          vc1_pop,
   output logic          d0_push,
   output logic          d1_push,
   output logic [BW-1:0] d_data,
   output logic [1:0]    arb_state,
   output logic          idle_out
);

   localparam logic [3:0] WMAX = 4'(VC0_WEIGHT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_STALL = 2'b10,
      S_DRAIN = 2'b11
   } state_t;

   state_t          state_q;
   logic [3:0]      wcnt_q, wcnt_d;
   // [0]: word popped last cycle, data on the VC bus now; [1]: word being pushed now
   logic [1:0]      vld_pipe_q, vld_pipe_d;
   logic            sel_q, sel_d;          // 1: the stage-0 word comes from VC1
   logic            d0_push_q, d0_push_d;
   logic            d1_push_q, d1_push_d;
   logic [BW-1:0]   d_data_q, d_data_d;
   logic [BW-1:0]   rd_word;
   logic            ok, grant_en;

   // Grant: new pops only while RUN is live and both destinations have headroom
   always_comb begin
      ok       = !d0_almost_full && !d1_almost_full;
      grant_en = !reset && (state_q == S_RUN) && active_in && ok;
      vc0_pop  = grant_en && !vc0_empty && (vc1_empty || (wcnt_q < WMAX));
      vc1_pop  = grant_en && !vc1_empty && !vc0_pop;
   end

   // Weight counter: counts VC0 grants, reset by a VC1 grant or by going idle
   always_comb begin
      wcnt_d = wcnt_q;
      if (state_q == S_IDLE)
         wcnt_d = '0;
      else if (vc1_pop)
         wcnt_d = '0;
      else if (vc0_pop && (wcnt_q < WMAX))
         wcnt_d = wcnt_q + 4'd1;
   end

   // Datapath: capture read data one cycle after the pop, steer by the destination bit
   always_comb begin
      vld_pipe_d = {vld_pipe_q[0], vc0_pop | vc1_pop};
      sel_d      = vc1_pop;
      rd_word    = sel_q ? vc1_data : vc0_data;
      d_data_d   = vld_pipe_q[0] ? rd_word : d_data_q;
      d1_push_d  = vld_pipe_q[0] &&  rd_word[DEST_BIT];
      d0_push_d  = vld_pipe_q[0] && !rd_word[DEST_BIT];
   end

   // Datapath and counter registers; reset discards any word in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt_q     <= '0;
         vld_pipe_q <= '0;
         sel_q      <= 1'b0;
         d_data_q   <= '0;
         d0_push_q  <= 1'b0;
         d1_push_q  <= 1'b0;
      end else begin
         wcnt_q     <= wcnt_d;
         vld_pipe_q <= vld_pipe_d;
         sel_q      <= sel_d;
         d_data_q   <= d_data_d;
         d0_push_q  <= d0_push_d;
         d1_push_q  <= d1_push_d;
      end
   end

   // Control FSM; DRAIN ignores active_in until the pipeline is empty
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (active_in) state_q <= S_RUN;
            S_RUN: begin
               if (!active_in)
                  state_q <= S_DRAIN;
               else if (d0_almost_full || d1_almost_full)
                  state_q <= S_STALL;
            end
            S_STALL: begin
               if (!active_in)
                  state_q <= S_DRAIN;
               else if (!d0_almost_full && !d1_almost_full)
                  state_q <= S_RUN;
            end
            S_DRAIN: if (vld_pipe_q == 2'b00) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign d0_push   = d0_push_q;
   assign d1_push   = d1_push_q;
   assign d_data    = d_data_q;
   assign arb_state = state_q;
   assign idle_out  = (state_q == S_IDLE) && (vld_pipe_q == 2'b00);

endmodule

// File: tb/tb_vc_arbiter_sched.sv
// Directed bench for vc_arbiter_sched: reset, weighting, steering, backpressure,
// deactivation/drain and mid-flight reset, with simple VC FIFO models.
module tb_vc_arbiter_sched;

   logic       clk = 1'b0;
   logic       reset, active_in, vc0_empty, vc1_empty;
   logic [5:0] vc0_data, vc1_data;
   logic       d0_almost_full, d1_almost_full;
   logic       vc0_pop, vc1_pop, d0_push, d1_push;
   logic [5:0] d_data;
   logic [1:0] arb_state;
   logic       idle_out;

   int total = 0;
   int bad   = 0;

   logic [5:0] q0 [16];
   logic [5:0] q1 [16];
   int n0, r0, n1, r1;

   logic [5:0] exp_w [12];
   logic       seq   [12];   // 0: VC0 pop, 1: VC1 pop

   vc_arbiter_sched #(.BW(6), .DEST_BIT(4), .VC0_WEIGHT(3)) dut (
      .clk(clk), .reset(reset), .active_in(active_in),
      .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_data(vc0_data), .vc1_data(vc1_data),
      .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
      .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
      .d0_push(d0_push), .d1_push(d1_push), .d_data(d_data),
      .arb_state(arb_state), .idle_out(idle_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string name, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
      end
   endtask

   // Entered at a negedge with inputs already set; checks, then advances one cycle
   // and updates the FIFO models from the pops seen this cycle.
   task automatic step(input string tag, input logic e_p0, input logic e_p1,
                       input logic e_d0, input logic e_d1, input logic [5:0] e_data,
                       input logic [1:0] e_st, input logic e_idle);
      logic p0, p1;
      #1;
      chk(tag, "vc0_pop",   {7'd0, vc0_pop},  {7'd0, e_p0});
      chk(tag, "vc1_pop",   {7'd0, vc1_pop},  {7'd0, e_p1});
      chk(tag, "d0_push",   {7'd0, d0_push},  {7'd0, e_d0});
      chk(tag, "d1_push",   {7'd0, d1_push},  {7'd0, e_d1});
      chk(tag, "d_data",    {2'd0, d_data},   {2'd0, e_data});
      chk(tag, "arb_state", {6'd0, arb_state},{6'd0, e_st});
      chk(tag, "idle_out",  {7'd0, idle_out}, {7'd0, e_idle});
      p0 = vc0_pop;
      p1 = vc1_pop;
      @(posedge clk);
      #1;
      if (p0 && r0 < n0) begin vc0_data = q0[r0]; r0++; end
      if (p1 && r1 < n1) begin vc1_data = q1[r1]; r1++; end
      vc0_empty = (r0 >= n0);
      vc1_empty = (r1 >= n1);
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] w;
      reset = 1'b1; active_in = 1'b1;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      vc0_data = '0; vc1_data = '0;
      for (int i = 0; i < 8; i++) q0[i] = 6'(i);
      q1[0] = 6'h18; q1[1] = 6'h19; q1[2] = 6'h1A; q1[3] = 6'h1B;
      n0 = 8; r0 = 0; n1 = 4; r1 = 0;
      vc0_empty = 1'b0; vc1_empty = 1'b0;
      exp_w = '{6'h00, 6'h01, 6'h02, 6'h18, 6'h03, 6'h04, 6'h05, 6'h19, 6'h06, 6'h07, 6'h1A, 6'h1B};
      seq   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

      // Reset with non-empty FIFOs and active_in high
      @(negedge clk);
      #1;
      chk("rst0", "vc0_pop", {7'd0, vc0_pop}, 8'd0);
      chk("rst0", "vc1_pop", {7'd0, vc1_pop}, 8'd0);
      @(negedge clk);
      step("rst1", 0, 0, 0, 0, 6'h00, 2'b00, 1);
      reset = 1'b0;
      step("wake", 0, 0, 0, 0, 6'h00, 2'b00, 1);

      // Weighting: pop order 0,0,0,1,0,0,0,1,0,0,1,1; push two cycles later
      for (int i = 0; i < 15; i++) begin
         logic ep0, ep1, ed0, ed1;
         ep0 = (i < 12) && !seq[i];
         ep1 = (i < 12) &&  seq[i];
         ed0 = 1'b0; ed1 = 1'b0;
         if (i >= 2) begin
            w   = exp_w[i-2];
            ed1 = w[4];
            ed0 = !w[4];
         end else if (i == 14) begin
            w = 6'h1B;
         end else begin
            w = 6'h00;
         end
         if (i == 14) begin ed0 = 1'b0; ed1 = 1'b0; w = 6'h1B; end
         step($sformatf("wt%0d", i), ep0, ep1, ed0, ed1, w, 2'b01, 0);
      end

      // Steering: 6'h10 goes to D1, 6'h05 to D0
      q0[0] = 6'h10; q0[1] = 6'h05; n0 = 2; r0 = 0; vc0_empty = 1'b0;
      step("st0", 1, 0, 0, 0, 6'h1B, 2'b01, 0);
      step("st1", 1, 0, 0, 0, 6'h1B, 2'b01, 0);
      step("st2", 0, 0, 0, 1, 6'h10, 2'b01, 0);
      step("st3", 0, 0, 1, 0, 6'h05, 2'b01, 0);
      step("st4", 0, 0, 0, 0, 6'h05, 2'b01, 0);

      // Backpressure; weight counter is at 2 on entry
      for (int i = 0; i < 6; i++) q0[i] = 6'(i + 1);
      n0 = 6; r0 = 0; vc0_empty = 1'b0;
      q1[0] = 6'h11; q1[1] = 6'h12; n1 = 2; r1 = 0; vc1_empty = 1'b0;
      step("bp0", 1, 0, 0, 0, 6'h05, 2'b01, 0);
      step("bp1", 0, 1, 0, 0, 6'h05, 2'b01, 0);
      step("bp2", 1, 0, 1, 0, 6'h01, 2'b01, 0);
      d0_almost_full = 1'b1;
      step("bp3", 0, 0, 0, 1, 6'h11, 2'b01, 0);
      step("bp4", 0, 0, 1, 0, 6'h02, 2'b10, 0);
      d0_almost_full = 1'b0;
      step("bp5", 0, 0, 0, 0, 6'h02, 2'b10, 0);
      step("bp6", 1, 0, 0, 0, 6'h02, 2'b01, 0);
      step("bp7", 1, 0, 0, 0, 6'h02, 2'b01, 0);
      step("bp8", 0, 1, 1, 0, 6'h03, 2'b01, 0);
      step("bp9", 1, 0, 1, 0, 6'h04, 2'b01, 0);

      // Deactivate mid-stream, then reassert during DRAIN
      active_in = 1'b0;
      step("dr0", 0, 0, 0, 1, 6'h12, 2'b01, 0);
      step("dr1", 0, 0, 1, 0, 6'h05, 2'b11, 0);
      active_in = 1'b1;
      step("dr2", 0, 0, 0, 0, 6'h05, 2'b11, 0);
      step("dr3", 0, 0, 0, 0, 6'h05, 2'b00, 1);
      step("dr4", 1, 0, 0, 0, 6'h05, 2'b01, 0);

      // Reset the cycle after a pop: the word is dropped, pops are forced low
      reset = 1'b1;
      q1[0] = 6'h2A; n1 = 1; r1 = 0; vc1_empty = 1'b0;
      step("mr0", 0, 0, 0, 0, 6'h05, 2'b01, 0);
      reset = 1'b0;
      step("mr1", 0, 0, 0, 0, 6'h00, 2'b00, 1);
      step("mr2", 0, 1, 0, 0, 6'h00, 2'b01, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
